// File: rtl/pwm_capture_scheduler.sv
// Purpose: collects RC-PWM decoder samples into per-channel slots and serialises them round-robin.
// Latency: a sample strobe in cycle 0 is presented in cycle 2; records are always separated by an idle cycle.
// Backpressure: a presented record is held until i_ready; newer samples overwrite pending slots and flag overrun.
module pwm_capture_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int CLK_FREQ = 50000000,
  parameter int STALE_US = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_CH-1:0]    i_pwm_ready,
  input  logic [16*NUM_CH-1:0] i_pwm_value,
  input  logic [NUM_CH-1:0]    i_ch_enable,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2:0]           o_ch,
  output logic [15:0]          o_value,
  output logic                 o_err,
  output logic [NUM_CH-1:0]    o_stale_mask,
  output logic [NUM_CH-1:0]    o_overrun_mask,
  input  logic [NUM_CH-1:0]    i_overrun_clr
);
  localparam logic [31:0] PRESC_MAX = 32'(CLK_FREQ / 1000000 - 1);
  localparam logic [15:0] STALE_MAX = 16'(STALE_US);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]       r_presc;
  logic              w_tick;
  logic [15:0]       r_slot      [NUM_CH];
  logic [15:0]       r_stale_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_pending, r_overrun, r_stale_q;
  logic [NUM_CH-1:0] w_cap, w_fs, w_stale, w_load, w_grant, w_pend_eff;
  logic [7:0]        w_pend8;
  logic [3:0]        w_idx;
  logic [2:0]        r_rr_ptr, w_sel;
  logic [15:0]       w_sel_val;
  logic              w_any, w_take;
  logic [2:0]        r_ch;
  logic [15:0]       r_value;
  logic              r_err;

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset || w_tick) r_presc <= '0;
    else                   r_presc <= r_presc + 32'd1;
  end

  // A real capture always wins over a failsafe raised in the same cycle.
  always_comb begin
    w_stale = '0;
    w_cap   = '0;
    w_fs    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_stale[k] = (r_stale_cnt[k] == STALE_MAX);
      w_cap[k]   = i_pwm_ready[k] & i_ch_enable[k];
      w_fs[k]    = w_stale[k] & ~r_stale_q[k] & i_ch_enable[k] & ~w_cap[k];
    end
  end

  assign w_load     = w_cap | w_fs;
  assign w_pend_eff = r_pending & i_ch_enable;

  // Scan downwards so the last hit is the first pending channel at or after rr_ptr.
  always_comb begin
    w_pend8                = '0;
    w_pend8[NUM_CH-1:0]    = w_pend_eff;
    w_sel                  = '0;
    w_any                  = 1'b0;
    w_idx                  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + 4'(i);
      if (w_idx >= 4'(NUM_CH)) w_idx = w_idx - 4'(NUM_CH);
      if (w_pend8[w_idx[2:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[2:0];
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && w_any;

  always_comb begin
    w_sel_val = '0;
    w_grant   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel == 3'(k)) w_sel_val = r_slot[k];
      w_grant[k] = w_take && (w_sel == 3'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
      r_overrun <= '0;
      r_stale_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_slot[k]      <= '0;
        r_stale_cnt[k] <= '0;
      end
    end else begin
      r_stale_q <= w_stale;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!i_ch_enable[k])  r_pending[k] <= 1'b0;
        else if (w_load[k])   r_pending[k] <= 1'b1;
        else if (w_grant[k])  r_pending[k] <= 1'b0;

        if (w_load[k] && r_pending[k] && !w_grant[k]) r_overrun[k] <= 1'b1;
        else if (i_overrun_clr[k])                    r_overrun[k] <= 1'b0;

        if (w_cap[k])     r_slot[k] <= i_pwm_value[16*k +: 16];
        else if (w_fs[k]) r_slot[k] <= 16'hFFFF;

        if (!i_ch_enable[k] || w_cap[k])              r_stale_cnt[k] <= '0;
        else if (w_tick && r_stale_cnt[k] != STALE_MAX) r_stale_cnt[k] <= r_stale_cnt[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any)   w_state_nxt = S_PRESENT;
      S_PRESENT: if (i_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ch     <= '0;
      r_value  <= '0;
      r_err    <= 1'b0;
      r_rr_ptr <= '0;
    end else if (w_take) begin
      r_ch     <= w_sel;
      r_value  <= w_sel_val;
      r_err    <= w_sel_val[15];
      r_rr_ptr <= (w_sel == 3'(NUM_CH - 1)) ? 3'd0 : w_sel + 3'd1;
    end
  end

  assign o_valid        = (r_state == S_PRESENT);
  assign o_ch           = r_ch;
  assign o_value        = r_value;
  assign o_err          = r_err;
  assign o_stale_mask   = w_stale;
  assign o_overrun_mask = r_overrun;
endmodule

// File: tb/tb_pwm_capture_scheduler.sv
// Bench for pwm_capture_scheduler: directed scenarios plus random traffic, all cycles checked
// against a record-level model built on tick counts and per-channel pending slots.
`timescale 1ns/1ps
module tb_pwm_capture_scheduler;
  localparam int NCH   = 4;
  localparam int CLKF  = 50_000_000;
  localparam int STALE = 100;
  localparam int PRESC = CLKF / 1_000_000;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   pwm_rdy, en, ovr_clr;
  logic [16*NCH-1:0] pwm_val;
  logic             rdy;
  logic             o_valid, o_err;
  logic [2:0]       o_ch;
  logic [15:0]      o_value;
  logic [NCH-1:0]   o_stale, o_ovr;
  int               n_vec = 0;
  int               n_err = 0;

  pwm_capture_scheduler #(.NUM_CH(NCH), .CLK_FREQ(CLKF), .STALE_US(STALE)) dut (
    .i_clk(clk), .i_reset(rst), .i_pwm_ready(pwm_rdy), .i_pwm_value(pwm_val),
    .i_ch_enable(en), .o_valid(o_valid), .i_ready(rdy), .o_ch(o_ch), .o_value(o_value),
    .o_err(o_err), .o_stale_mask(o_stale), .o_overrun_mask(o_ovr), .i_overrun_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  // Reference model state: presented record, pending slots, and tick bookkeeping.
  bit          m_valid;
  int          m_ch;
  logic [15:0] m_val;
  bit          m_pend [NCH];
  logic [15:0] m_slot [NCH];
  bit          m_ovr  [NCH];
  int          m_rr, m_cyc, m_ticks;
  int          m_mark [NCH];
  bit          m_stale_prev [NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_is_stale(input int k);
    return (m_ticks - m_mark[k]) >= STALE;
  endfunction

  task automatic model_step();
    bit st [NCH];
    bit tick, cap, fs, granted, still_pend;
    int sel, c;
    if (rst) begin
      m_valid = 0; m_ch = 0; m_val = '0; m_rr = 0; m_cyc = 0; m_ticks = 0;
      for (int k = 0; k < NCH; k++) begin
        m_pend[k] = 0; m_slot[k] = '0; m_ovr[k] = 0; m_mark[k] = 0; m_stale_prev[k] = 0;
      end
      return;
    end
    for (int k = 0; k < NCH; k++) st[k] = m_is_stale(k);
    tick  = (m_cyc % PRESC) == PRESC - 1;
    m_cyc = m_cyc + 1;
    sel = -1;
    if (!m_valid) begin
      for (int i = 0; i < NCH; i++) begin
        c = (m_rr + i) % NCH;
        if (sel < 0 && m_pend[c] && en[c]) sel = c;
      end
    end
    if (m_valid) begin
      if (rdy) m_valid = 0;
    end else if (sel >= 0) begin
      m_valid = 1; m_ch = sel; m_val = m_slot[sel]; m_rr = (sel + 1) % NCH;
    end
    if (tick) m_ticks = m_ticks + 1;
    for (int k = 0; k < NCH; k++) begin
      cap        = pwm_rdy[k] && en[k];
      fs         = st[k] && !m_stale_prev[k] && en[k] && !cap;
      granted    = (sel == k);
      still_pend = m_pend[k] && !granted;
      if (cap || fs) begin
        if (still_pend)      m_ovr[k] = 1;
        else if (ovr_clr[k]) m_ovr[k] = 0;
        m_slot[k] = cap ? pwm_val[16*k +: 16] : 16'hFFFF;
        m_pend[k] = 1;
      end else begin
        if (ovr_clr[k]) m_ovr[k] = 0;
        if (granted)    m_pend[k] = 0;
      end
      if (!en[k]) m_pend[k] = 0;
      if (!en[k] || cap) m_mark[k] = m_ticks;
      m_stale_prev[k] = st[k];
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] es, eo;
    for (int k = 0; k < NCH; k++) begin
      es[k] = m_is_stale(k);
      eo[k] = m_ovr[k];
    end
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("ch", 32'(o_ch), 32'(m_ch));
    chk("value", 32'(o_value), 32'(m_val));
    chk("err", 32'(o_err), 32'(m_val[15]));
    chk("stale_mask", 32'(o_stale), 32'(es));
    chk("overrun_mask", 32'(o_ovr), 32'(eo));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse(input int ch, input logic [15:0] v);
    pwm_rdy = '0;
    pwm_rdy[ch] = 1'b1;
    pwm_val[16*ch +: 16] = v;
    step();
    pwm_rdy = '0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i;
    i = 0;
    while (!o_valid && i < max) begin
      step();
      i++;
    end
    chk({tag, "_seen"}, 32'(o_valid), 32'd1);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (o_valid) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, seen2, st2;
    rst = 1'b1; pwm_rdy = '0; pwm_val = '0; en = '1; ovr_clr = '0; rdy = 1'b1;
    do_reset();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_value", 32'(o_value), 32'd0);
    chk("rst_masks", 32'({o_stale, o_ovr}), 32'd0);

    // single sample latency
    pulse(2, 16'd1500);
    chk("ss_c1_valid", 32'(o_valid), 32'd0);
    step();
    chk("ss_c2_valid", 32'(o_valid), 32'd1);
    chk("ss_ch", 32'(o_ch), 32'd2);
    chk("ss_value", 32'(o_value), 32'd1500);
    chk("ss_err", 32'(o_err), 32'd0);
    step();
    chk("ss_idle", 32'(o_valid), 32'd0);
    run(4);

    // round robin, two bursts
    do_reset();
    pwm_rdy = '1;
    pwm_val = {16'd1300, 16'd1200, 16'd1100, 16'd1000};
    step();
    pwm_rdy = '0;
    for (int i = 0; i < NCH; i++) begin
      step();
      chk("rr_valid", 32'(o_valid), 32'd1);
      chk("rr_ch", 32'(o_ch), 32'(i));
      chk("rr_value", 32'(o_value), 32'(1000 + 100 * i));
      step();
      chk("rr_gap", 32'(o_valid), 32'd0);
    end
    pwm_rdy = '1;
    pwm_val = {16'd2300, 16'd2200, 16'd2100, 16'd2000};
    step();
    pwm_rdy = '0;
    step();
    step();
    chk("rr2_ch", 32'(o_ch), 32'd0);
    chk("rr2_value", 32'(o_value), 32'd2000);
    run(10);

    // backpressure and overrun
    rdy = 1'b0;
    pulse(0, 16'd1000);
    run(4);
    pulse(1, 16'd1100);
    run(4);
    pulse(1, 16'd1900);
    run(190);
    chk("bp_valid", 32'(o_valid), 32'd1);
    chk("bp_ch", 32'(o_ch), 32'd0);
    chk("bp_value", 32'(o_value), 32'd1000);
    chk("bp_ovr", 32'(o_ovr), 32'b0010);
    rdy = 1'b1;
    step();
    wait_valid("bp_rel", 10);
    chk("bp_rel_ch", 32'(o_ch), 32'd1);
    chk("bp_rel_value", 32'(o_value), 32'd1900);
    rdy = 1'b0;
    ovr_clr = 4'b0010;
    step();
    ovr_clr = '0;
    chk("bp_clr", 32'(o_ovr), 32'd0);
    pulse(1, 16'd1111);
    ovr_clr = 4'b0010;
    pulse(1, 16'd1222);
    ovr_clr = '0;
    chk("bp_set_wins", 32'(o_ovr), 32'b0010);
    rdy = 1'b1;
    run(10);

    // error flag passthrough
    pulse(3, 16'hC4E8);
    wait_valid("er", 10);
    chk("er_value", 32'(o_value), 32'hC4E8);
    chk("er_err", 32'(o_err), 32'd1);
    chk("er_stale", 32'(o_stale), 32'd0);
    run(5);

    // staleness, failsafe, and capture coincident with the stale edge
    en = 4'b0001;
    do_reset();
    pulse(0, 16'd1500);
    cnt = 0;
    while (!o_stale[0] && cnt < 6000) begin
      step();
      cnt++;
    end
    chk("st_rise", 32'(o_stale[0]), 32'd1);
    chk("st_window", 32'(cnt >= 4940 && cnt <= 5060), 32'd1);
    wait_valid("st_fs", 10);
    chk("st_fs_ch", 32'(o_ch), 32'd0);
    chk("st_fs_value", 32'(o_value), 32'hFFFF);
    chk("st_fs_err", 32'(o_err), 32'd1);
    run(3);
    pulse(0, 16'd1600);
    chk("st_clear", 32'(o_stale[0]), 32'd0);
    wait_valid("st_new", 10);
    chk("st_new_value", 32'(o_value), 32'd1600);
    run(3);
    cnt = 0;
    while (!o_stale[0] && cnt < 6000) begin
      step();
      cnt++;
    end
    chk("cs_rise", 32'(o_stale[0]), 32'd1);
    pulse(0, 16'd1234);
    wait_valid("cs", 10);
    chk("cs_value", 32'(o_value), 32'd1234);
    step();
    count_valid(40, cnt);
    chk("cs_no_failsafe", 32'(cnt), 32'd0);

    // disable a pending channel
    en = '1;
    do_reset();
    rdy = 1'b0;
    pulse(0, 16'd100);
    pulse(2, 16'd300);
    en = 4'b1011;
    rdy = 1'b1;
    seen2 = 0;
    st2 = 0;
    for (int i = 0; i < 5100; i++) begin
      step();
      if (o_valid && o_ch == 3'd2) seen2 = 1;
      if (o_stale[2]) st2 = 1;
    end
    chk("en_no_ch2", 32'(seen2), 32'd0);
    chk("en_no_stale2", 32'(st2), 32'd0);

    // reset while a record is presented
    en = '1;
    do_reset();
    rdy = 1'b0;
    pulse(1, 16'd1100);
    wait_valid("rm", 10);
    pulse(3, 16'd1300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", 32'(o_valid), 32'd0);
    chk("rm_ch", 32'(o_ch), 32'd0);
    chk("rm_value", 32'(o_value), 32'd0);
    chk("rm_err", 32'(o_err), 32'd0);
    chk("rm_masks", 32'({o_stale, o_ovr}), 32'd0);
    rdy = 1'b1;
    count_valid(30, cnt);
    chk("rm_quiet", 32'(cnt), 32'd0);

    // random traffic: ch0 busy, ch3 silent so it goes stale, ch1/ch2 toggle enable
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < NCH; k++) begin
        int per;
        per = (k == 0) ? 8 : (k == 1) ? 40 : (k == 2) ? 400 : 20000;
        pwm_rdy[k] = ($urandom_range(per - 1) == 0);
        pwm_val[16*k +: 16] = 16'($urandom);
        if ((k == 1 || k == 2) && $urandom_range(799) == 0) en[k] = ~en[k];
        ovr_clr[k] = ($urandom_range(29) == 0);
      end
      rdy = ($urandom_range(3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
